// File: rtl/distance_poll_master.sv
// Polling bus initiator for the ultrasonic distance sensor: reads STATUS, then DISTANCE when
// the sensor reports valid data, and derives debounced car_present and stale flags.
module distance_poll_master #(
    parameter int unsigned POLL_PERIOD   = 50000,
    parameter int unsigned HOLD_CYCLES   = 2,
    parameter logic [15:0] STATUS_ADDR   = 16'h0908,
    parameter logic [15:0] DISTANCE_ADDR = 16'h0900,
    parameter logic [15:0] NEAR_THRESH   = 16'd300,
    parameter logic [15:0] FAR_THRESH    = 16'd400,
    parameter int unsigned DEBOUNCE      = 3,
    parameter int unsigned STALE_LIMIT   = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    output logic        io_select,
    output logic [15:0] address,
    input  logic [15:0] read_data,
    output logic [15:0] distance,
    output logic        distance_valid,
    output logic        car_present,
    output logic        stale,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, STAT, GAP, DIST} state_t;

    localparam int TIMER_W = $clog2(POLL_PERIOD + 1);
    localparam int HOLD_W  = $clog2(HOLD_CYCLES + 1);
    localparam int MISS_W  = $clog2(STALE_LIMIT + 1);
    localparam int DEB_W   = $clog2(DEBOUNCE + 1);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(POLL_PERIOD - 1);
    localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [MISS_W-1:0]  MISS_LIMIT = MISS_W'(STALE_LIMIT);
    localparam logic [DEB_W-1:0]   DEB_LIMIT  = DEB_W'(DEBOUNCE);

    state_t              state_q, state_d;
    logic [TIMER_W-1:0]  timer_q, timer_d;
    logic [HOLD_W-1:0]   holdCount_q, holdCount_d;
    logic [MISS_W-1:0]   missCount_q, missCount_d;
    logic [DEB_W-1:0]    debCount_q, debCount_d;
    logic                ioSelect_q, ioSelect_d;
    logic [15:0]         address_q, address_d;
    logic [15:0]         distance_q, distance_d;
    logic                distValid_q, distValid_d;
    logic                carPresent_q, carPresent_d;
    logic                stale_q, stale_d;
    logic                tick, holdLast, statusSample, distSample, qualifies;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            timer_q      <= '0;
            holdCount_q  <= '0;
            missCount_q  <= '0;
            debCount_q   <= '0;
            ioSelect_q   <= 1'b0;
            address_q    <= '0;
            distance_q   <= '0;
            distValid_q  <= 1'b0;
            carPresent_q <= 1'b0;
            stale_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            holdCount_q  <= holdCount_d;
            missCount_q  <= missCount_d;
            debCount_q   <= debCount_d;
            ioSelect_q   <= ioSelect_d;
            address_q    <= address_d;
            distance_q   <= distance_d;
            distValid_q  <= distValid_d;
            carPresent_q <= carPresent_d;
            stale_q      <= stale_d;
        end
    end

    // The poll timer free-runs while enabled; ticks outside IDLE are simply lost.
    always_comb begin
        tick = enable && (timer_q == TIMER_LAST);
        if (!enable || tick) begin
            timer_d = '0;
        end else begin
            timer_d = timer_q + 1'b1;
        end
        holdLast = (holdCount_q == HOLD_LAST);
        if ((state_q == STAT || state_q == DIST) && !holdLast) begin
            holdCount_d = holdCount_q + 1'b1;
        end else begin
            holdCount_d = '0;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (tick) state_d = STAT;
            STAT: if (holdLast) state_d = read_data[0] ? GAP : IDLE;
            GAP:  state_d = DIST;
            DIST: if (holdLast) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Bus outputs are registered, so they are decoded from the state being entered.
    always_comb begin
        ioSelect_d = 1'b0;
        address_d  = '0;
        case (state_d)
            STAT: begin
                ioSelect_d = 1'b1;
                address_d  = STATUS_ADDR;
            end
            DIST: begin
                ioSelect_d = 1'b1;
                address_d  = DISTANCE_ADDR;
            end
            default: ;
        endcase
    end

    always_comb begin
        statusSample = (state_q == STAT) && holdLast;
        distSample   = (state_q == DIST) && holdLast;
        qualifies    = carPresent_q ? (read_data > FAR_THRESH) : (read_data < NEAR_THRESH);
        distance_d   = distance_q;
        distValid_d  = 1'b0;
        carPresent_d = carPresent_q;
        debCount_d   = debCount_q;
        missCount_d  = missCount_q;
        stale_d      = stale_q;
        if (statusSample) begin
            if (!read_data[0]) begin
                if (missCount_q != MISS_LIMIT) missCount_d = missCount_q + 1'b1;
                if (missCount_d == MISS_LIMIT) stale_d = 1'b1;
            end
        end
        // A qualifying sample in the direction away from the current state builds the streak.
        if (distSample) begin
            distance_d  = read_data;
            distValid_d = 1'b1;
            missCount_d = '0;
            stale_d     = 1'b0;
            if (qualifies) begin
                if (debCount_q + 1'b1 == DEB_LIMIT) begin
                    carPresent_d = !carPresent_q;
                    debCount_d   = '0;
                end else begin
                    debCount_d = debCount_q + 1'b1;
                end
            end else begin
                debCount_d = '0;
            end
        end
    end

    assign io_select      = ioSelect_q;
    assign address        = address_q;
    assign distance       = distance_q;
    assign distance_valid = distValid_q;
    assign car_present    = carPresent_q;
    assign stale          = stale_q;
    assign busy           = (state_q != IDLE);

endmodule

// File: tb/tb_distance_poll_master.sv
// Self-checking bench for distance_poll_master: a poll-level timeline model predicts every
// output each cycle while directed scenarios and a randomized phase drive the sensor slave.
module tb_distance_poll_master;

    localparam int P   = 20;
    localparam int H   = 2;
    localparam int DEB = 3;
    localparam int SL  = 4;
    localparam logic [15:0] SA   = 16'h0908;
    localparam logic [15:0] DA   = 16'h0900;
    localparam logic [15:0] NEAR = 16'd300;
    localparam logic [15:0] FAR  = 16'd400;

    typedef struct packed {
        logic        st;
        logic [15:0] d;
    } poll_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [15:0] read_data;
    logic        io_select;
    logic [15:0] address;
    logic [15:0] distance;
    logic        distance_valid;
    logic        car_present;
    logic        stale;
    logic        busy;

    poll_t       planQ[$];
    bit          randomMode = 1'b0;
    logic        curStatus = 1'b0;
    logic [14:0] statusJunk = '0;
    logic [15:0] curDist = '0;
    logic [15:0] junk = '0;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          runCnt = 0;
    int          tTick = 0;
    int          missCnt = 0;
    int          debCnt = 0;
    bit          txnActive = 1'b0;
    bit          txnStatus = 1'b0;
    bit          mStale = 1'b0;
    bit          mCar = 1'b0;
    logic [15:0] txnDist = '0;
    logic [15:0] mDist = '0;
    bit          expIo = 1'b0;
    bit          expBusy = 1'b0;
    bit          expDv = 1'b0;
    logic [15:0] expAddr = '0;

    distance_poll_master #(
        .POLL_PERIOD(P), .HOLD_CYCLES(H), .STATUS_ADDR(SA), .DISTANCE_ADDR(DA),
        .NEAR_THRESH(NEAR), .FAR_THRESH(FAR), .DEBOUNCE(DEB), .STALE_LIMIT(SL)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .io_select(io_select), .address(address),
        .read_data(read_data), .distance(distance), .distance_valid(distance_valid),
        .car_present(car_present), .stale(stale), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) junk = 16'($urandom);

    assign read_data = !io_select ? junk :
                       (address == SA) ? {statusJunk, curStatus} :
                       (address == DA) ? curDist : junk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=%0h expected=%0h cycle=%0d", tag, observed, expected, cyc);
        end
    endtask

    task automatic applyStimulus(input logic st, input logic [15:0] d);
        poll_t p;
        p.st = st;
        p.d  = d;
        planQ.push_back(p);
    endtask

    task automatic pickPoll(output poll_t p);
        int r;
        if (planQ.size() > 0) begin
            p = planQ.pop_front();
        end else if (randomMode) begin
            p.st = ($urandom_range(0, 3) != 0);
            r = $urandom_range(0, 9);
            if (r < 4)       p.d = 16'($urandom_range(0, 299));
            else if (r < 7)  p.d = 16'($urandom_range(401, 65535));
            else if (r == 7) p.d = NEAR;
            else if (r == 8) p.d = FAR;
            else             p.d = 16'd0;
        end else begin
            p.st = 1'b0;
            p.d  = 16'd0;
        end
    endtask

    // Timeline model: a poll accepted at tick cycle T occupies fixed offsets after T.
    always @(posedge clk) begin : model
        int    off;
        bit    tickPrev;
        poll_t p;
        cyc++;
        if (reset) begin
            runCnt = 0; txnActive = 1'b0; missCnt = 0; mStale = 1'b0;
            mCar = 1'b0; debCnt = 0; mDist = '0;
        end else begin
            tickPrev = enable && (runCnt % P == P - 1);
            runCnt = enable ? runCnt + 1 : 0;
            if (tickPrev && (!txnActive || (cyc - 1 - tTick) >= (txnStatus ? 2 * H + 2 : H + 1))) begin
                pickPoll(p);
                txnActive = 1'b1;
                tTick = cyc - 1;
                txnStatus = p.st;
                txnDist = p.d;
                curStatus = p.st;
                curDist = p.d;
                statusJunk = 15'($urandom);
            end
            if (txnActive) begin
                off = cyc - tTick;
                if (!txnStatus && off == H + 1) begin
                    if (missCnt < SL) missCnt++;
                    if (missCnt == SL) mStale = 1'b1;
                end
                if (txnStatus && off == 2 * H + 2) begin
                    mDist = txnDist;
                    missCnt = 0;
                    mStale = 1'b0;
                    if (mCar ? (txnDist > FAR) : (txnDist < NEAR)) debCnt++;
                    else debCnt = 0;
                    if (debCnt == DEB) begin
                        mCar = !mCar;
                        debCnt = 0;
                    end
                end
            end
        end
        expIo = 1'b0; expAddr = '0; expBusy = 1'b0; expDv = 1'b0;
        if (txnActive) begin
            off = cyc - tTick;
            if (off >= 1 && off <= H) begin
                expIo = 1'b1; expAddr = SA; expBusy = 1'b1;
            end else if (txnStatus && off == H + 1) begin
                expBusy = 1'b1;
            end else if (txnStatus && off >= H + 2 && off <= 2 * H + 1) begin
                expIo = 1'b1; expAddr = DA; expBusy = 1'b1;
            end else if (txnStatus && off == 2 * H + 2) begin
                expDv = 1'b1;
            end
        end
        #1;
        checkOutput("io_select", 32'(io_select), 32'(expIo));
        checkOutput("address", 32'(address), 32'(expAddr));
        checkOutput("busy", 32'(busy), 32'(expBusy));
        checkOutput("distance_valid", 32'(distance_valid), 32'(expDv));
        checkOutput("distance", 32'(distance), 32'(mDist));
        checkOutput("car_present", 32'(car_present), 32'(mCar));
        checkOutput("stale", 32'(stale), 32'(mStale));
    end

    task automatic resetDut();
        @(negedge clk);
        reset = 1'b1;
        enable = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic waitBus(input logic [15:0] addr, output int n);
        bit found;
        found = 1'b0;
        n = 0;
        while (!found && n < 60) begin
            @(negedge clk);
            n++;
            if (io_select === 1'b1 && address === addr) found = 1'b1;
        end
        checkOutput("bus access seen", 32'(found), 1);
    endtask

    task automatic waitIdle();
        bit found;
        int n;
        found = 1'b0;
        n = 0;
        while (!found && n < 400) begin
            @(negedge clk);
            n++;
            if (planQ.size() == 0 && !expBusy) found = 1'b1;
        end
        checkOutput("idle reached", 32'(found), 1);
    endtask

    initial begin
        int n;
        int cnt;
        bit found;
        reset = 1'b1;
        enable = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("reset io_select", 32'(io_select), 0);
        checkOutput("reset busy", 32'(busy), 0);
        checkOutput("reset distance", 32'(distance), 0);

        $display("[TB] scenario 1: first poll timing");
        applyStimulus(1'b1, 16'd1234);
        resetDut();
        enable = 1'b1;
        waitBus(SA, n);
        checkOutput("s1 first select cycle", 32'(n), 20);
        waitIdle();
        checkOutput("s1 distance", 32'(distance), 1234);
        enable = 1'b0;

        $display("[TB] scenario 2: debounce rise and fall");
        resetDut();
        enable = 1'b1;
        repeat (3) applyStimulus(1'b1, 16'd250);
        waitIdle();
        checkOutput("s2 car rises", 32'(car_present), 1);
        applyStimulus(1'b1, 16'd350);
        repeat (3) applyStimulus(1'b1, 16'd450);
        waitIdle();
        checkOutput("s2 car falls", 32'(car_present), 0);
        enable = 1'b0;

        $display("[TB] scenario 3: in-band sample breaks the streak");
        resetDut();
        enable = 1'b1;
        applyStimulus(1'b1, 16'd250);
        applyStimulus(1'b1, 16'd350);
        applyStimulus(1'b1, 16'd250);
        applyStimulus(1'b1, 16'd250);
        waitIdle();
        checkOutput("s3 car stays low", 32'(car_present), 0);
        enable = 1'b0;

        $display("[TB] scenario 4: stale sensor");
        resetDut();
        enable = 1'b1;
        repeat (4) applyStimulus(1'b0, 16'd0);
        waitIdle();
        checkOutput("s4 stale set", 32'(stale), 1);
        applyStimulus(1'b1, 16'd500);
        waitIdle();
        checkOutput("s4 stale cleared", 32'(stale), 0);
        checkOutput("s4 distance", 32'(distance), 500);
        checkOutput("s4 car unchanged", 32'(car_present), 0);
        enable = 1'b0;

        $display("[TB] scenario 5: reset mid-DIST");
        resetDut();
        enable = 1'b1;
        repeat (3) applyStimulus(1'b1, 16'd100);
        applyStimulus(1'b1, 16'd200);
        found = 1'b0;
        n = 0;
        while (!found && n < 400) begin
            @(negedge clk);
            n++;
            if (planQ.size() == 0 && io_select === 1'b1 && address === DA) found = 1'b1;
        end
        checkOutput("s5 last DIST seen", 32'(found), 1);
        checkOutput("s5 car before reset", 32'(car_present), 1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        applyStimulus(1'b1, 16'd600);
        checkOutput("s5 io_select", 32'(io_select), 0);
        checkOutput("s5 busy", 32'(busy), 0);
        checkOutput("s5 distance", 32'(distance), 0);
        checkOutput("s5 car", 32'(car_present), 0);
        waitBus(SA, n);
        checkOutput("s5 resume cycle", 32'(n), 20);
        waitIdle();
        enable = 1'b0;

        $display("[TB] scenario 6: enable dropped during STAT");
        applyStimulus(1'b1, 16'd321);
        enable = 1'b1;
        waitBus(SA, n);
        enable = 1'b0;
        waitIdle();
        checkOutput("s6 distance", 32'(distance), 321);
        cnt = 0;
        repeat (100) begin
            @(negedge clk);
            if (io_select !== 1'b0) cnt++;
        end
        checkOutput("s6 quiet bus", 32'(cnt), 0);

        $display("[TB] randomized phase");
        randomMode = 1'b1;
        enable = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            reset = ($urandom_range(0, 299) == 0);
            if (enable) begin
                if ($urandom_range(0, 99) < 1) enable = 1'b0;
            end else begin
                if ($urandom_range(0, 99) < 5) enable = 1'b1;
            end
        end
        reset = 1'b0;
        enable = 1'b0;
        repeat (10) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/distance_poll_master.md
Name: distance_poll_master

Overview:
- Bus initiator for the memory-mapped ultrasonic distance sensor slave.
- Periodically drives io_select/address to read the STATUS register, then the DISTANCE register when status reports valid data.
- Registers the returned distance and derives a debounced, hysteretic car_present flag plus a stale-sensor flag.
- Sits between the sensor's slave interface and the parking/occupancy logic.

Parameters:
- POLL_PERIOD, 50000: cycles between poll attempts (1 ms at 50 MHz).
- HOLD_CYCLES, 2: cycles io_select/address are held per read; read_data is sampled on the last held cycle. Minimum 1.
- STATUS_ADDR, 16'h0908: address of the sensor status register; bit0 = data valid.
- DISTANCE_ADDR, 16'h0900: address of the sensor distance register.
- NEAR_THRESH, 16'd300: distance strictly below this is a "near" sample.
- FAR_THRESH, 16'd400: distance strictly above this is a "far" sample. Must be >= NEAR_THRESH.
- DEBOUNCE, 3: consecutive qualifying samples required to change car_present. Minimum 1.
- STALE_LIMIT, 8: consecutive invalid-status polls before stale asserts. Minimum 1.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- enable  in  1  polling enable
- io_select  out  1  bus select to sensor slave (registered)
- address  out  16  bus address (registered)
- read_data  in  16  slave read data; valid only while io_select=1, may be Z/X otherwise
- distance  out  16  last captured distance
- distance_valid  out  1  one-cycle pulse when distance updates
- car_present  out  1  debounced occupancy flag
- stale  out  1  sensor has not reported valid data for STALE_LIMIT polls
- busy  out  1  high whenever state is not IDLE

Behaviour:
- Reset (one clk edge with reset=1), from any state including mid-transaction:
  - Outputs: io_select=0, address=0, distance=0, distance_valid=0, car_present=0, stale=0, busy=0.
  - Internals: state=IDLE; timer, hold count, miss count and debounce count cleared to 0.
- Timer:
  - Counts 0..POLL_PERIOD-1 while enable=1, wraps to 0, and produces a tick on the cycle timer==POLL_PERIOD-1.
  - enable=0 holds the timer at 0.
  - A tick is acted on only in IDLE. Ticks arriving in other states are dropped, not queued.
- Deasserting enable mid-transaction does not abort it; the current sequence completes and the FSM returns to IDLE.
- FSM, with states IDLE, STAT, GAP, DIST:
  - IDLE: io_select=0, address=0. On tick -> STAT.
  - STAT: io_select=1, address=STATUS_ADDR for HOLD_CYCLES cycles. On the last cycle, sample read_data[0].
    - 1 -> GAP, miss count unchanged.
    - 0 -> miss count increments (saturating at STALE_LIMIT). When it reaches STALE_LIMIT, stale=1 on the next cycle. Next state IDLE.
  - GAP: one cycle with io_select=0, address=0 (bus turnaround) -> DIST.
  - DIST: io_select=1, address=DISTANCE_ADDR for HOLD_CYCLES cycles. On the last cycle, read_data is registered into distance, and distance_valid pulses high the following cycle. Miss count clears to 0, stale clears to 0. Next state IDLE.
- read_data is never sampled outside the last held cycle of STAT or DIST.
- Latency: first io_select rises the cycle after the tick. distance_valid rises 2*HOLD_CYCLES+2 cycles after the tick.
- Car detection, evaluated once per distance_valid using the new distance:
  - If car_present=0: a near sample increments the debounce count; any other sample clears it. When the count reaches DEBOUNCE, car_present=1 and the count clears.
  - If car_present=1: a far sample increments the count; any other sample clears it. When the count reaches DEBOUNCE, car_present=0 and the count clears.
  - Samples between the thresholds (NEAR_THRESH..FAR_THRESH inclusive) never count toward either direction.
  - car_present changes in the same cycle distance_valid is high.
- stale does not alter car_present; the last value is retained.
- All comparisons are unsigned 16-bit. distance=0 counts as near.

Test Plan:
Parameters for all scenarios: POLL_PERIOD=20, HOLD_CYCLES=2, DEBOUNCE=3, STALE_LIMIT=4.
1. Reset, then enable=1 at cycle 0; slave returns status=1, distance=16'd1234 -> io_select=1 with address=0x0908 at cycles 20-21; io_select=0 at cycle 22; address=0x0900 at cycles 23-24; distance=1234 and distance_valid=1 at cycle 25 only.
2. Distances 250, 250, 250 on three consecutive polls -> car_present rises on the third distance_valid. Then 350, 450, 450, 450 -> the 350 clears the count, and car_present falls on the third 450.
3. Near sequence 250, 350, 250, 250 -> car_present stays 0 (debounce count broken by the in-band 350).
4. Status=0 on four consecutive polls -> no DIST reads issued; stale=1 after the fourth. Next poll with status=1, distance=500 -> stale=0 with distance_valid; car_present unchanged.
5. reset=1 asserted during DIST (second held cycle) -> next cycle io_select=0, busy=0, distance=0, car_present=0. Polling resumes 20 cycles after reset drops, with enable=1.
6. enable dropped during STAT -> the STAT, GAP and DIST sequence completes with distance_valid pulsing; afterwards no io_select activity for 100 cycles while enable=0.
